// File: rtl/auto_color_balance_pkg.sv
`default_nettype none
// ============================================================================
// Module      : auto_color_balance_pkg
// Description : Shared video definitions for the auto colour balance block.
//               Covers RGB565 field positions, 565->888 expansion and the
//               "plus10" code ladder.
// Revision    : 1.0 - initial release
// ============================================================================
package auto_color_balance_pkg;

    // RGB565 field positions: {R[15:11], G[10:5], B[4:0]}
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // The adjuster applies 10 levels per code step; codes saturate at 7
    localparam int PLUS10_STEP = 10;
    localparam int CODE_MAX    = 7;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Widen each field to 8 bits by replicating its low bits into the LSBs
    function automatic rgb888_t expand_rgb565(input logic [15:0] px);
        rgb888_t o;
        o.r = {px[R_MSB:R_LSB], px[R_LSB+2:R_LSB]};
        o.g = {px[G_MSB:G_LSB], px[G_LSB+1:G_LSB]};
        o.b = {px[B_MSB:B_LSB], px[B_LSB+2:B_LSB]};
        return o;
    endfunction

    // Number of ladder steps (10, 20, ... 70) the deficit reaches
    function automatic logic [2:0] plus10_code(input logic [7:0] diff);
        logic [2:0] code;
        code = 3'd0;
        for (int k = 1; k <= CODE_MAX; k++) begin
            if (int'(diff) >= PLUS10_STEP * k) begin
                code = code + 3'd1;
            end
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/auto_color_balance_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Restoring sequential divider, one quotient bit per clock.
//               The first bit is resolved in the start cycle itself, so the
//               quotient is ready and done pulses DIVIDEND_W cycles after
//               start.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int DIVIDEND_W = 29,
    parameter int DIVISOR_W  = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int              CNT_W     = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DIVISOR_W-1:0]  w_rem_src;
    logic [DIVISOR_W-1:0]  w_dvs;
    logic                  w_bit;
    logic [DIVISOR_W:0]    w_trial;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_rem_next;

    // One restoring step; on start it works directly from the new operands
    always_comb begin
        w_rem_src  = start ? '0 : rem_q;
        w_dvs      = start ? divisor : dvs_q;
        w_bit      = start ? dividend[DIVIDEND_W-1] : dvd_q[DIVIDEND_W-1];
        w_trial    = {w_rem_src, w_bit};
        w_ge       = (w_trial >= {1'b0, w_dvs});
        w_rem_next = w_ge ? DIVISOR_W'(w_trial - {1'b0, w_dvs}) : w_trial[DIVISOR_W-1:0];
    end

    // Operand load, bit iteration and completion pulse
    always_comb begin
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            dvs_d  = divisor;
            dvd_d  = {dividend[DIVIDEND_W-2:0], 1'b0};
            rem_d  = w_rem_next;
            quo_d  = {{(DIVIDEND_W-1){1'b0}}, w_ge};
            cnt_d  = CNT_W'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
            rem_d = w_rem_next;
            quo_d = {quo_q[DIVIDEND_W-2:0], w_ge};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule
`default_nettype wire

// File: rtl/auto_color_balance.sv
`default_nettype none
// ============================================================================
// Module      : auto_color_balance
// Description : Measures per-channel RGB frame means on an RGB565 video
//               stream and derives the four 3-bit "plus10" control codes
//               for the brightness/colour adjuster.
// Revision    : 1.0 - initial release
// ============================================================================
module auto_color_balance
    import auto_color_balance_pkg::*;
#(
    parameter int PIX_CNT_W = 21,
    parameter int TARGET_Y  = 128,
    parameter bit VS_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        auto_en,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic [15:0] data_in,
    output logic [2:0]  rgb_ctrl_plus10,
    output logic [2:0]  r_ctrl_plus10,
    output logic [2:0]  g_ctrl_plus10,
    output logic [2:0]  b_ctrl_plus10,
    output logic [7:0]  mean_r,
    output logic [7:0]  mean_g,
    output logic [7:0]  mean_b,
    output logic        stats_valid
);

    localparam int         SUM_W      = PIX_CNT_W + 8;
    localparam logic [7:0] C_TARGET_Y = 8'(TARGET_Y);

    localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_DIV       = 2'd2;
    localparam logic [1:0] ST_UPDATE    = 2'd3;

    logic [1:0]           state_q, state_d;
    logic                 vs_d_q, vs_d_d;
    logic [SUM_W-1:0]     sum_r_q, sum_r_d;
    logic [SUM_W-1:0]     sum_g_q, sum_g_d;
    logic [SUM_W-1:0]     sum_b_q, sum_b_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]           mean_r_q, mean_r_d;
    logic [7:0]           mean_g_q, mean_g_d;
    logic [7:0]           mean_b_q, mean_b_d;
    logic [2:0]           rgb_code_q, rgb_code_d;
    logic [2:0]           r_code_q, r_code_d;
    logic [2:0]           g_code_q, g_code_d;
    logic [2:0]           b_code_q, b_code_d;
    logic                 stats_valid_q, stats_valid_d;

    rgb888_t              w_px;
    logic                 w_vs_edge;
    logic                 w_cnt_sat;
    logic                 w_start;
    logic                 w_done_r, w_done_g, w_done_b;
    logic                 w_div_done;
    logic [SUM_W-1:0]     w_quo_r, w_quo_g, w_quo_b;
    logic [7:0]           w_mr, w_mg, w_mb, w_mmax, w_y, w_dy;
    logic [9:0]           w_y_sum;
    logic                 w_unused_hs;

    // Sync timing is carried alongside the stream but never affects results
    assign w_unused_hs = hs_in;

    // Quotients can never exceed 255 for real video, but clamp defensively
    function automatic logic [7:0] sat8(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:8]) ? 8'hFF : q[7:0];
    endfunction

    assign w_vs_edge  = (vs_in == VS_POL) && (vs_d_q != VS_POL);
    assign w_cnt_sat  = &pix_cnt_q;
    assign w_start    = (state_q == ST_IDLE) && w_vs_edge && (pix_cnt_q != '0);
    assign w_div_done = w_done_r & w_done_g & w_done_b;

    // Pixel expansion, luma estimate and code ladder from the fresh quotients
    always_comb begin
        w_px    = expand_rgb565(data_in);
        w_mr    = sat8(w_quo_r);
        w_mg    = sat8(w_quo_g);
        w_mb    = sat8(w_quo_b);
        w_y_sum = {2'b00, w_mr} + {1'b0, w_mg, 1'b0} + {2'b00, w_mb};
        w_y     = w_y_sum[9:2];
        w_dy    = (w_y < C_TARGET_Y) ? (C_TARGET_Y - w_y) : 8'd0;
        w_mmax  = w_mr;
        if (w_mg > w_mmax) w_mmax = w_mg;
        if (w_mb > w_mmax) w_mmax = w_mb;
    end

    // Accumulators, frame-boundary handling and the control FSM
    always_comb begin
        vs_d_d        = vs_in;
        state_d       = state_q;
        sum_r_d       = sum_r_q;
        sum_g_d       = sum_g_q;
        sum_b_d       = sum_b_q;
        pix_cnt_d     = pix_cnt_q;
        mean_r_d      = mean_r_q;
        mean_g_d      = mean_g_q;
        mean_b_d      = mean_b_q;
        rgb_code_d    = rgb_code_q;
        r_code_d      = r_code_q;
        g_code_d      = g_code_q;
        b_code_d      = b_code_q;
        stats_valid_d = 1'b0;

        // A pixel coincident with the boundary opens the new frame
        if (w_vs_edge) begin
            sum_r_d   = de_in ? {{PIX_CNT_W{1'b0}}, w_px.r} : '0;
            sum_g_d   = de_in ? {{PIX_CNT_W{1'b0}}, w_px.g} : '0;
            sum_b_d   = de_in ? {{PIX_CNT_W{1'b0}}, w_px.b} : '0;
            pix_cnt_d = de_in ? PIX_CNT_W'(1) : '0;
        end else if (de_in && !w_cnt_sat) begin
            sum_r_d   = sum_r_q + {{PIX_CNT_W{1'b0}}, w_px.r};
            sum_g_d   = sum_g_q + {{PIX_CNT_W{1'b0}}, w_px.g};
            sum_b_d   = sum_b_q + {{PIX_CNT_W{1'b0}}, w_px.b};
            pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
        end

        case (state_q)
            ST_WAIT_SYNC: begin
                if (w_vs_edge) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_start) state_d = ST_DIV;
            end
            ST_DIV: begin
                if (w_div_done) begin
                    mean_r_d      = w_mr;
                    mean_g_d      = w_mg;
                    mean_b_d      = w_mb;
                    rgb_code_d    = auto_en ? plus10_code(w_dy) : 3'd0;
                    r_code_d      = auto_en ? plus10_code(w_mmax - w_mr) : 3'd0;
                    g_code_d      = auto_en ? plus10_code(w_mmax - w_mg) : 3'd0;
                    b_code_d      = auto_en ? plus10_code(w_mmax - w_mb) : 3'd0;
                    stats_valid_d = 1'b1;
                    state_d       = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_WAIT_SYNC;
            end
        endcase
    end

    // State registers; vs history resets to the active level so a sync held
    // active through reset is not mistaken for a fresh edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_WAIT_SYNC;
            vs_d_q        <= VS_POL;
            sum_r_q       <= '0;
            sum_g_q       <= '0;
            sum_b_q       <= '0;
            pix_cnt_q     <= '0;
            mean_r_q      <= '0;
            mean_g_q      <= '0;
            mean_b_q      <= '0;
            rgb_code_q    <= '0;
            r_code_q      <= '0;
            g_code_q      <= '0;
            b_code_q      <= '0;
            stats_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_d_q        <= vs_d_d;
            sum_r_q       <= sum_r_d;
            sum_g_q       <= sum_g_d;
            sum_b_q       <= sum_b_d;
            pix_cnt_q     <= pix_cnt_d;
            mean_r_q      <= mean_r_d;
            mean_g_q      <= mean_g_d;
            mean_b_q      <= mean_b_d;
            rgb_code_q    <= rgb_code_d;
            r_code_q      <= r_code_d;
            g_code_q      <= g_code_d;
            b_code_q      <= b_code_d;
            stats_valid_q <= stats_valid_d;
        end
    end

    seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(PIX_CNT_W)) u_div_r (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (sum_r_q),
        .divisor  (pix_cnt_q),
        .done     (w_done_r),
        .quotient (w_quo_r)
    );

    seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(PIX_CNT_W)) u_div_g (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (sum_g_q),
        .divisor  (pix_cnt_q),
        .done     (w_done_g),
        .quotient (w_quo_g)
    );

    seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(PIX_CNT_W)) u_div_b (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (sum_b_q),
        .divisor  (pix_cnt_q),
        .done     (w_done_b),
        .quotient (w_quo_b)
    );

    assign mean_r          = mean_r_q;
    assign mean_g          = mean_g_q;
    assign mean_b          = mean_b_q;
    assign rgb_ctrl_plus10 = rgb_code_q;
    assign r_ctrl_plus10   = r_code_q;
    assign g_ctrl_plus10   = g_code_q;
    assign b_ctrl_plus10   = b_code_q;
    assign stats_valid     = stats_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_auto_color_balance.sv
`default_nettype none
// ============================================================================
// Module      : tb_auto_color_balance
// Description : Directed self-checking bench for auto_color_balance. Frame
//               results are predicted when the closing sync edge is driven
//               and checked when stats_valid is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_auto_color_balance;

    logic        clk = 1'b0;
    logic        rst;
    logic        auto_en;
    logic        hs_in;
    logic        vs_in;
    logic        de_in;
    logic [15:0] data_in;
    logic [2:0]  rgb_ctrl_plus10, r_ctrl_plus10, g_ctrl_plus10, b_ctrl_plus10;
    logic [7:0]  mean_r, mean_g, mean_b;
    logic        stats_valid;

    auto_color_balance dut (
        .clk             (clk),
        .rst             (rst),
        .auto_en         (auto_en),
        .hs_in           (hs_in),
        .vs_in           (vs_in),
        .de_in           (de_in),
        .data_in         (data_in),
        .rgb_ctrl_plus10 (rgb_ctrl_plus10),
        .r_ctrl_plus10   (r_ctrl_plus10),
        .g_ctrl_plus10   (g_ctrl_plus10),
        .b_ctrl_plus10   (b_ctrl_plus10),
        .mean_r          (mean_r),
        .mean_g          (mean_g),
        .mean_b          (mean_b),
        .stats_valid     (stats_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int exp_cyc;
        int mr, mg, mb;
        int cy, cr, cg, cb;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame model state
    bit synced;
    int last_t;
    int fr_cnt, fr_sr, fr_sg, fr_sb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ladder(input int d);
        int c;
        c = d / 10;
        return (c > 7) ? 7 : c;
    endfunction

    function automatic exp_t predict(input int t, input bit ae);
        exp_t e;
        int y, dy, mx;
        e.exp_cyc = t + 30;
        e.mr = fr_sr / fr_cnt; if (e.mr > 255) e.mr = 255;
        e.mg = fr_sg / fr_cnt; if (e.mg > 255) e.mg = 255;
        e.mb = fr_sb / fr_cnt; if (e.mb > 255) e.mb = 255;
        y  = (e.mr + 2 * e.mg + e.mb) / 4;
        dy = (y < 128) ? 128 - y : 0;
        mx = e.mr;
        if (e.mg > mx) mx = e.mg;
        if (e.mb > mx) mx = e.mb;
        e.cy = ae ? ladder(dy)        : 0;
        e.cr = ae ? ladder(mx - e.mr) : 0;
        e.cg = ae ? ladder(mx - e.mg) : 0;
        e.cb = ae ? ladder(mx - e.mb) : 0;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, "_mean_r"}, mean_r, e.mr);
        chk({tag, "_mean_g"}, mean_g, e.mg);
        chk({tag, "_mean_b"}, mean_b, e.mb);
        chk({tag, "_rgb_code"}, rgb_ctrl_plus10, e.cy);
        chk({tag, "_r_code"}, r_ctrl_plus10, e.cr);
        chk({tag, "_g_code"}, g_ctrl_plus10, e.cg);
        chk({tag, "_b_code"}, b_ctrl_plus10, e.cb);
    endtask

    // Start-of-frame sync pulse; predicts the result for the frame it closes
    task automatic vs_edge(input bit ae);
        @(negedge clk);
        vs_in   = 1'b1;
        auto_en = ae;
        de_in   = 1'b0;
        hs_in   = 1'b0;
        if (!synced) begin
            synced = 1'b1;
        end else if ((cyc - last_t) >= 30 && fr_cnt != 0) begin
            sb.push_back(predict(cyc, ae));
            last_t = cyc;
        end
        fr_cnt = 0; fr_sr = 0; fr_sg = 0; fr_sb = 0;
        repeat (3) @(negedge clk);
        vs_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // 4 lines x 16 active pixels of one colour, random data in blanking
    task automatic body(input logic [15:0] px, input bit de_on);
        logic [15:0] p;
        p = px;
        for (int l = 0; l < 4; l++) begin
            for (int x = 0; x < 16; x++) begin
                @(negedge clk);
                de_in   = de_on;
                hs_in   = 1'b0;
                data_in = p;
                if (de_on) begin
                    fr_cnt++;
                    fr_sr += {p[15:11], p[13:11]};
                    fr_sg += {p[10:5], p[6:5]};
                    fr_sb += {p[4:0], p[2:0]};
                end
            end
            for (int h = 0; h < 4; h++) begin
                @(negedge clk);
                de_in   = 1'b0;
                hs_in   = (h < 2);
                data_in = 16'($urandom);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard consumer: each prediction must see stats_valid on its cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("stats_valid_on_time", stats_valid, 1);
                check_outputs("frame", e);
                last_exp = e;
            end else if (stats_valid) begin
                chk("unexpected_stats_valid", stats_valid, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no completion expected finish before 300000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t zero;
        zero = '{0, 0, 0, 0, 0, 0, 0, 0};
        last_exp = zero;
        synced   = 1'b0;
        last_t   = -1000;
        fr_cnt = 0; fr_sr = 0; fr_sg = 0; fr_sb = 0;
        rst = 1'b1; auto_en = 1'b1; hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0; data_in = 16'h0;
        repeat (3) @(negedge clk);
        check_outputs("reset", zero);
        chk("reset_stats_valid", stats_valid, 0);
        rst = 1'b0;

        // Mid-grey: first edge only synchronises, then two results
        vs_edge(1); body(16'h8410, 1'b1);
        vs_edge(1); body(16'h8410, 1'b1);
        vs_edge(1); body(16'h8410, 1'b1);
        vs_edge(1); body(16'h0000, 1'b1);
        vs_edge(1); body(16'h4208, 1'b1);
        vs_edge(1); body(16'h840C, 1'b1);
        vs_edge(1); body(16'h0000, 1'b1);
        // Black frame closed with auto mode off: means update, codes forced 0
        vs_edge(0); body(16'h840C, 1'b1);
        // Frame with no active pixels must not produce a result
        vs_edge(1); body(16'h4208, 1'b0);
        vs_edge(1);
        repeat (40) @(negedge clk);
        check_outputs("hold_after_empty", last_exp);

        // Second edge 10 cycles after the first, while dividing
        body(16'h4208, 1'b1);
        vs_edge(1);
        repeat (4) @(negedge clk);
        vs_edge(1);
        body(16'h8410, 1'b1);
        vs_edge(1); body(16'h0000, 1'b1);

        // Reset in the middle of a division
        vs_edge(1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        synced = 1'b0;
        last_t = -1000;
        fr_cnt = 0; fr_sr = 0; fr_sg = 0; fr_sb = 0;
        repeat (2) @(negedge clk);
        check_outputs("mid_div_reset", zero);
        chk("mid_div_reset_stats_valid", stats_valid, 0);
        last_exp = zero;
        rst = 1'b0;
        body(16'h4208, 1'b1);
        vs_edge(1); body(16'h840C, 1'b1);
        vs_edge(1);
        repeat (60) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
